acc_multi_eng_ctrl: RTL and testbench

Kernel-level ap_ctrl_chain controller for NUM_ENG convolution engines. It accepts kernel starts and dispatches each one to the lowest-index idle, enabled engine as a one-cycle op_start pulse. It tracks per-engine completion (end_conv followed by write-buffer drain) and reports each finished job through a completion FIFO that drives ap_done and ap_done_id. It sits between the host control-register block and the engine array, replacing the single-engine controller.

---
 rtl/acc_ctrl_pkg.sv | 15 +
 rtl/acc_done_fifo.sv | 64 ++++++
 rtl/acc_multi_eng_ctrl.sv | 135 +++++++++++++
 tb/tb_acc_multi_eng_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/acc_ctrl_pkg.sv
// Shared definitions for the multi-engine ap_ctrl_chain controller: engine-state
// encoding and the engine-id width helper.
package acc_ctrl_pkg;

  localparam logic [1:0] EngIdle = 2'd0;
  localparam logic [1:0] EngBusy = 2'd1;
  localparam logic [1:0] EngFin  = 2'd2;

  // clog2 clamped to 1 so a single-engine build still has a 1-bit id.
  function automatic int unsigned id_width(input int unsigned n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/acc_done_fifo.sv
// Synchronous completion FIFO holding retired engine ids; supports push and pop
// in the same cycle, and presents zero at the head while empty.
module acc_done_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2,
  parameter int unsigned CntW  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DepthCnt);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/acc_multi_eng_ctrl.sv
// Kernel-level ap_ctrl_chain controller: dispatches starts to the lowest idle enabled
// engine, tracks end_conv + write-buffer drain per engine and queues finished ids.
module acc_multi_eng_ctrl
  import acc_ctrl_pkg::*;
#(
  parameter int unsigned NumEng = 4,
  parameter int unsigned IdW    = id_width(NumEng)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ap_start_i,
  input  logic              ap_continue_i,
  output logic              ap_ready_o,
  output logic              ap_idle_o,
  output logic              ap_done_o,
  output logic [IdW-1:0]    ap_done_id_o,
  input  logic [NumEng-1:0] eng_en_i,
  output logic [NumEng-1:0] op_start_o,
  input  logic [NumEng-1:0] end_conv_i,
  input  logic [NumEng-1:0] write_buffer_wait_i,
  output logic [NumEng-1:0] busy_vec_o
);

  localparam logic [IdW+1:0] NumEngW = (IdW + 2)'(NumEng);

  logic [NumEng-1:0][1:0] state_q, state_d;
  logic [NumEng-1:0]      fin_pend_q, fin_pend_d;
  logic [NumEng-1:0]      op_start_q, op_start_d;

  logic [NumEng-1:0] idle_vec, fin_vec, elig;
  logic [NumEng-1:0] disp_oh, ret_oh;
  logic [IdW-1:0]    ret_id;
  logic              accept, push, pop;
  logic [IdW+1:0]    busy_cnt, occ;
  logic [IdW:0]      fifo_cnt;
  logic              fifo_full, fifo_empty;

  always_comb begin
    for (int i = 0; i < NumEng; i++) begin
      idle_vec[i] = (state_q[i] == EngIdle);
      fin_vec[i]  = (state_q[i] == EngFin);
    end
  end

  // An engine pulsed this cycle is already BUSY; the op_start mask is kept for safety.
  assign elig    = eng_en_i & idle_vec & ~op_start_q;
  assign disp_oh = elig & (~elig + 1'b1);
  assign ret_oh  = fin_vec & (~fin_vec + 1'b1);
  assign push    = |fin_vec;

  always_comb begin
    ret_id = '0;
    for (int i = NumEng - 1; i >= 0; i--) begin
      if (fin_vec[i]) ret_id = IdW'(i);
    end
  end

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < NumEng; i++) begin
      busy_cnt = busy_cnt + {{(IdW + 1){1'b0}}, ~idle_vec[i]};
    end
  end

  // Outstanding jobs plus queued completions never exceed the FIFO depth.
  assign occ        = busy_cnt + {1'b0, fifo_cnt};
  assign ap_ready_o = (|elig) && (occ < NumEngW);
  assign accept     = ap_start_i && ap_ready_o;
  assign pop        = ap_done_o && ap_continue_i;

  always_comb begin
    state_d    = state_q;
    fin_pend_d = fin_pend_q;
    op_start_d = accept ? disp_oh : '0;
    for (int i = 0; i < NumEng; i++) begin
      case (state_q[i])
        EngIdle: begin
          if (accept && disp_oh[i]) state_d[i] = EngBusy;
        end
        EngBusy: begin
          if (fin_pend_q[i] && write_buffer_wait_i[i]) begin
            state_d[i]    = EngFin;
            fin_pend_d[i] = 1'b0;
          end else if (end_conv_i[i]) begin
            fin_pend_d[i] = 1'b1;
          end
        end
        EngFin: begin
          if (ret_oh[i]) state_d[i] = EngIdle;
        end
        default: begin
          state_d[i]    = EngIdle;
          fin_pend_d[i] = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= '0;
      fin_pend_q <= '0;
      op_start_q <= '0;
    end else begin
      state_q    <= state_d;
      fin_pend_q <= fin_pend_d;
      op_start_q <= op_start_d;
    end
  end

  acc_done_fifo #(
    .Depth (NumEng),
    .Width (IdW),
    .CntW  (IdW + 1)
  ) u_done_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (ret_id),
    .pop_i       (pop),
    .head_o      (ap_done_id_o),
    .count_o     (fifo_cnt),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign op_start_o = op_start_q;
  assign busy_vec_o = ~idle_vec;
  assign ap_done_o  = ~fifo_empty;
  assign ap_idle_o  = (busy_cnt == '0) && fifo_empty;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_acc_multi_eng_ctrl.sv
// Directed-vector bench for acc_multi_eng_ctrl with NUM_ENG=4 and hand-computed
// expectations for dispatch order, completion ordering and reset behaviour.
module tb_acc_multi_eng_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ap_start, ap_continue;
  logic       ap_ready, ap_idle, ap_done;
  logic [1:0] ap_done_id;
  logic [3:0] eng_en, op_start, end_conv, wbw, busy_vec;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  acc_multi_eng_ctrl #(
    .NumEng (4)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ap_start_i          (ap_start),
    .ap_continue_i       (ap_continue),
    .ap_ready_o          (ap_ready),
    .ap_idle_o           (ap_idle),
    .ap_done_o           (ap_done),
    .ap_done_id_o        (ap_done_id),
    .eng_en_i            (eng_en),
    .op_start_o          (op_start),
    .end_conv_i          (end_conv),
    .write_buffer_wait_i (wbw),
    .busy_vec_o          (busy_vec)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    ap_continue = 1'b1;
    tick();
    ap_continue = 1'b0;
    #1;
  endtask

  logic [3:0] exp_b2b [6];

  initial begin
    exp_b2b[0] = 4'b0001; exp_b2b[1] = 4'b0010; exp_b2b[2] = 4'b0100;
    exp_b2b[3] = 4'b1000; exp_b2b[4] = 4'b0000; exp_b2b[5] = 4'b0000;

    rst_n = 1'b0; ap_start = 1'b0; ap_continue = 1'b0;
    eng_en = 4'hF; end_conv = '0; wbw = '0;
    tick(); tick();
    check_eq("rst_op_start", 32'(op_start), 32'h0);
    check_eq("rst_busy_vec", 32'(busy_vec), 32'h0);
    check_eq("rst_ap_done", 32'(ap_done), 32'h0);
    check_eq("rst_done_id", 32'(ap_done_id), 32'h0);
    check_eq("rst_idle", 32'(ap_idle), 32'h1);
    check_eq("rst_ready", 32'(ap_ready), 32'h1);
    rst_n = 1'b1;
    tick();

    // Single job on engine 0.
    ap_start = 1'b1;
    #1 check_eq("t1_ready", 32'(ap_ready), 32'h1);
    tick();
    ap_start = 1'b0;
    #1;
    check_eq("t1_op_start", 32'(op_start), 32'h1);
    check_eq("t1_busy", 32'(busy_vec), 32'h1);
    check_eq("t1_not_idle", 32'(ap_idle), 32'h0);
    tick();
    check_eq("t1_pulse_1cyc", 32'(op_start), 32'h0);
    end_conv = 4'b0001; wbw = 4'b0001;
    tick();
    end_conv = '0;
    tick();
    check_eq("t1_fin_not_done", 32'(ap_done), 32'h0);
    check_eq("t1_fin_busy", 32'(busy_vec), 32'h1);
    tick();
    check_eq("t1_done", 32'(ap_done), 32'h1);
    check_eq("t1_done_id", 32'(ap_done_id), 32'h0);
    check_eq("t1_busy_clr", 32'(busy_vec), 32'h0);
    pop_one();
    check_eq("t1_popped", 32'(ap_done), 32'h0);
    check_eq("t1_idle", 32'(ap_idle), 32'h1);

    // ap_continue with nothing queued is ignored.
    pop_one();
    check_eq("t1_spurious_cont", 32'(ap_done), 32'h0);
    check_eq("t1_spurious_idle", 32'(ap_idle), 32'h1);

    // Back-to-back starts fill all four engines, then ap_ready drops.
    ap_start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq($sformatf("t2_op_start_%0d", i), 32'(op_start), 32'(exp_b2b[i]));
    end
    ap_start = 1'b0;
    #1;
    check_eq("t2_ready_low", 32'(ap_ready), 32'h0);
    check_eq("t2_all_busy", 32'(busy_vec), 32'hF);

    // All four finish together; retire one per cycle, FIFO fills to 4.
    end_conv = 4'hF; wbw = 4'hF;
    tick();
    end_conv = '0;
    tick();
    tick();
    check_eq("t4_first_done", 32'(ap_done), 32'h1);
    check_eq("t4_first_id", 32'(ap_done_id), 32'h0);
    check_eq("t4_busy_partial", 32'(busy_vec), 32'hE);
    tick(); tick(); tick();
    check_eq("t4_busy_empty", 32'(busy_vec), 32'h0);
    check_eq("t4_fifo_full_ready", 32'(ap_ready), 32'h0);
    check_eq("t4_head_id", 32'(ap_done_id), 32'h0);
    pop_one();
    check_eq("t4_ready_after_pop", 32'(ap_ready), 32'h1);
    check_eq("t4_next_id", 32'(ap_done_id), 32'h1);
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    #1;
    check_eq("t4_refill_op_start", 32'(op_start), 32'h1);
    check_eq("t4_refill_ready", 32'(ap_ready), 32'h0);
    for (int i = 1; i < 4; i++) begin
      check_eq($sformatf("t4_pop_id_%0d", i), 32'(ap_done_id), 32'(i));
      pop_one();
    end
    check_eq("t4_drained", 32'(ap_done), 32'h0);
    end_conv = 4'b0001;
    tick();
    end_conv = '0;
    tick(); tick();
    check_eq("t4_refill_done_id", 32'(ap_done_id), 32'h0);
    check_eq("t4_refill_done", 32'(ap_done), 32'h1);
    pop_one();
    check_eq("t4_idle", 32'(ap_idle), 32'h1);

    // Enable mask 1010: dispatch to 1 then 3; end_conv on idle engine 0 ignored.
    eng_en = 4'b1010; wbw = '0;
    #1 check_eq("t5_ready", 32'(ap_ready), 32'h1);
    ap_start = 1'b1;
    tick();
    check_eq("t5_op_first", 32'(op_start), 32'h2);
    tick();
    check_eq("t5_op_second", 32'(op_start), 32'h8);
    tick();
    check_eq("t5_op_none", 32'(op_start), 32'h0);
    check_eq("t5_ready_low", 32'(ap_ready), 32'h0);
    ap_start = 1'b0;
    end_conv = 4'b0001; wbw = 4'hF;
    tick();
    end_conv = '0;
    tick(); tick();
    check_eq("t5_idle_endconv_ignored", 32'(ap_done), 32'h0);
    check_eq("t5_busy_1_3", 32'(busy_vec), 32'hA);

    // Engines 1 and 3 finish in the same cycle: ids 1 then 3.
    end_conv = 4'b1010;
    tick();
    end_conv = '0;
    tick(); tick();
    check_eq("t3_done", 32'(ap_done), 32'h1);
    check_eq("t3_id_first", 32'(ap_done_id), 32'h1);
    check_eq("t3_busy_3_waits", 32'(busy_vec), 32'h8);
    tick();
    check_eq("t3_busy_clear", 32'(busy_vec), 32'h0);
    check_eq("t3_head_still_1", 32'(ap_done_id), 32'h1);
    pop_one();
    check_eq("t3_id_second", 32'(ap_done_id), 32'h3);
    check_eq("t3_done_second", 32'(ap_done), 32'h1);
    pop_one();
    check_eq("t3_empty", 32'(ap_done), 32'h0);
    check_eq("t3_idle", 32'(ap_idle), 32'h1);

    // Reset with two jobs busy and one completion queued.
    eng_en = 4'hF; wbw = '0;
    ap_start = 1'b1;
    tick(); tick(); tick();
    ap_start = 1'b0;
    end_conv = 4'b0001; wbw = 4'b0001;
    tick();
    end_conv = '0;
    tick(); tick();
    check_eq("t6_pre_done", 32'(ap_done), 32'h1);
    check_eq("t6_pre_busy", 32'(busy_vec), 32'h6);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_done", 32'(ap_done), 32'h0);
    check_eq("t6_rst_busy", 32'(busy_vec), 32'h0);
    check_eq("t6_rst_op_start", 32'(op_start), 32'h0);
    check_eq("t6_rst_id", 32'(ap_done_id), 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("t6_idle_after", 32'(ap_idle), 32'h1);
    check_eq("t6_ready_after", 32'(ap_ready), 32'h1);
    tick(); tick();
    check_eq("t6_no_stale_done", 32'(ap_done), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
